// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage
// Brief    : RV32I execute stage with operand forwarding, ALU, branch
//            resolution, PC redirect and the EX/MEM pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstb,
    // ID/EX pipeline register
    input  logic [XLEN-1:0] IdEx_Pc,
    input  logic [XLEN-1:0] IdEx_RegDataA,
    input  logic [XLEN-1:0] IdEx_RegDataB,
    input  logic [XLEN-1:0] IdEx_Imm,
    input  logic [4:0]      IdEx_RegRs1,
    input  logic [4:0]      IdEx_RegRs2,
    input  logic [4:0]      IdEx_RegRd,
    input  logic [2:0]      IdEx_Funct3,
    input  logic [3:0]      IdEx_AluOp,
    input  logic            IdEx_AluSrc,
    input  logic            IdEx_Branch,
    input  logic            IdEx_PcSrc,
    input  logic            IdEx_JalrSel,
    input  logic            IdEx_AluB_Pc4_Sel,
    input  logic            IdEx_MemRead,
    input  logic            IdEx_MemWrite,
    input  logic            IdEx_MemToReg,
    input  logic            IdEx_RegWrite,
    // EX/MEM pipeline register
    output logic [4:0]      ExMem_RegRd,
    output logic            ExMem_RegWrite,
    output logic            ExMem_MemRead,
    output logic            ExMem_MemWrite,
    output logic            ExMem_MemToReg,
    output logic [XLEN-1:0] ExMem_AluResult,
    output logic [XLEN-1:0] ExMem_StoreData,
    output logic [2:0]      ExMem_Funct3,
    // MEM/WB forwarding source
    input  logic [4:0]      MemWb_RegRd,
    input  logic            MemWb_RegWrite,
    input  logic [XLEN-1:0] Wb_RegWData,
    // Redirect and flush
    output logic            Ex_IdExFlush,
    output logic            Ex_IfIdFlush,
    output logic            Ex_PcLoad,
    output logic [XLEN-1:0] Ex_PcTarget
);

    localparam logic [3:0] c_ALU_ADD   = 4'd0;
    localparam logic [3:0] c_ALU_SUB   = 4'd1;
    localparam logic [3:0] c_ALU_SLL   = 4'd2;
    localparam logic [3:0] c_ALU_SLT   = 4'd3;
    localparam logic [3:0] c_ALU_SLTU  = 4'd4;
    localparam logic [3:0] c_ALU_XOR   = 4'd5;
    localparam logic [3:0] c_ALU_SRL   = 4'd6;
    localparam logic [3:0] c_ALU_SRA   = 4'd7;
    localparam logic [3:0] c_ALU_OR    = 4'd8;
    localparam logic [3:0] c_ALU_AND   = 4'd9;
    localparam logic [3:0] c_ALU_PASSB = 4'd10;
    localparam logic [3:0] c_ALU_AUIPC = 4'd11;

    localparam logic [2:0] c_BR_EQ  = 3'b000;
    localparam logic [2:0] c_BR_NE  = 3'b001;
    localparam logic [2:0] c_BR_LT  = 3'b100;
    localparam logic [2:0] c_BR_GE  = 3'b101;
    localparam logic [2:0] c_BR_LTU = 3'b110;
    localparam logic [2:0] c_BR_GEU = 3'b111;

    localparam logic [XLEN-1:0] c_FOUR = XLEN'(4);

    logic [XLEN-1:0] w_fwd_a;
    logic [XLEN-1:0] w_fwd_b;
    logic [XLEN-1:0] w_alu_b;
    logic [XLEN-1:0] w_alu_out;
    logic [XLEN-1:0] w_result;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_target_sum;
    logic [XLEN-1:0] w_target;
    logic [4:0]      w_shamt;
    logic            w_cond;
    logic            w_taken;

    // EX/MEM wins over MEM/WB because it holds the younger value; x0 never forwards.
    always_comb begin
        w_fwd_a = IdEx_RegDataA;
        if (ExMem_RegWrite && (ExMem_RegRd != 5'd0) && (ExMem_RegRd == IdEx_RegRs1)) begin
            w_fwd_a = ExMem_AluResult;
        end else if (MemWb_RegWrite && (MemWb_RegRd != 5'd0) && (MemWb_RegRd == IdEx_RegRs1)) begin
            w_fwd_a = Wb_RegWData;
        end
    end

    always_comb begin
        w_fwd_b = IdEx_RegDataB;
        if (ExMem_RegWrite && (ExMem_RegRd != 5'd0) && (ExMem_RegRd == IdEx_RegRs2)) begin
            w_fwd_b = ExMem_AluResult;
        end else if (MemWb_RegWrite && (MemWb_RegRd != 5'd0) && (MemWb_RegRd == IdEx_RegRs2)) begin
            w_fwd_b = Wb_RegWData;
        end
    end

    assign w_alu_b    = IdEx_AluSrc ? IdEx_Imm : w_fwd_b;
    assign w_shamt    = w_alu_b[4:0];
    assign w_pc_plus4 = IdEx_Pc + c_FOUR;

    always_comb begin
        w_alu_out = '0;
        case (IdEx_AluOp)
            c_ALU_ADD:   w_alu_out = w_fwd_a + w_alu_b;
            c_ALU_SUB:   w_alu_out = w_fwd_a - w_alu_b;
            c_ALU_SLL:   w_alu_out = w_fwd_a << w_shamt;
            c_ALU_SLT:   w_alu_out = {{(XLEN-1){1'b0}}, ($signed(w_fwd_a) < $signed(w_alu_b))};
            c_ALU_SLTU:  w_alu_out = {{(XLEN-1){1'b0}}, (w_fwd_a < w_alu_b)};
            c_ALU_XOR:   w_alu_out = w_fwd_a ^ w_alu_b;
            c_ALU_SRL:   w_alu_out = w_fwd_a >> w_shamt;
            c_ALU_SRA:   w_alu_out = $unsigned($signed(w_fwd_a) >>> w_shamt);
            c_ALU_OR:    w_alu_out = w_fwd_a | w_alu_b;
            c_ALU_AND:   w_alu_out = w_fwd_a & w_alu_b;
            c_ALU_PASSB: w_alu_out = w_alu_b;
            c_ALU_AUIPC: w_alu_out = IdEx_Pc + IdEx_Imm;
            default:     w_alu_out = '0;
        endcase
    end

    assign w_result = IdEx_AluB_Pc4_Sel ? w_pc_plus4 : w_alu_out;

    // Branch compare always uses forwarded rs2, never the immediate.
    always_comb begin
        w_cond = 1'b0;
        case (IdEx_Funct3)
            c_BR_EQ:  w_cond = (w_fwd_a == w_fwd_b);
            c_BR_NE:  w_cond = (w_fwd_a != w_fwd_b);
            c_BR_LT:  w_cond = ($signed(w_fwd_a) <  $signed(w_fwd_b));
            c_BR_GE:  w_cond = ($signed(w_fwd_a) >= $signed(w_fwd_b));
            c_BR_LTU: w_cond = (w_fwd_a <  w_fwd_b);
            c_BR_GEU: w_cond = (w_fwd_a >= w_fwd_b);
            default:  w_cond = 1'b0;
        endcase
    end

    assign w_taken      = IdEx_Branch & (IdEx_PcSrc | w_cond);
    assign w_target_sum = (IdEx_JalrSel ? w_fwd_a : IdEx_Pc) + IdEx_Imm;
    assign w_target     = IdEx_JalrSel ? {w_target_sum[XLEN-1:1], 1'b0} : w_target_sum;

    assign Ex_PcLoad    = w_taken;
    assign Ex_IdExFlush = w_taken;
    assign Ex_IfIdFlush = w_taken;
    assign Ex_PcTarget  = w_taken ? w_target : w_pc_plus4;

    // Memory writes are masked on control transfers as a guard against bad decode.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            ExMem_RegRd     <= '0;
            ExMem_RegWrite  <= 1'b0;
            ExMem_MemRead   <= 1'b0;
            ExMem_MemWrite  <= 1'b0;
            ExMem_MemToReg  <= 1'b0;
            ExMem_AluResult <= '0;
            ExMem_StoreData <= '0;
            ExMem_Funct3    <= '0;
        end else begin
            ExMem_RegRd     <= IdEx_RegRd;
            ExMem_RegWrite  <= IdEx_RegWrite;
            ExMem_MemRead   <= IdEx_MemRead;
            ExMem_MemWrite  <= IdEx_MemWrite & ~IdEx_Branch;
            ExMem_MemToReg  <= IdEx_MemToReg;
            ExMem_AluResult <= w_result;
            ExMem_StoreData <= w_fwd_b;
            ExMem_Funct3    <= IdEx_Funct3;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage
// Brief    : Directed self-checking bench for the ex_stage execute stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_stage;

    logic        clk;
    logic        rstb;
    logic [31:0] IdEx_Pc, IdEx_RegDataA, IdEx_RegDataB, IdEx_Imm;
    logic [4:0]  IdEx_RegRs1, IdEx_RegRs2, IdEx_RegRd;
    logic [2:0]  IdEx_Funct3;
    logic [3:0]  IdEx_AluOp;
    logic        IdEx_AluSrc, IdEx_Branch, IdEx_PcSrc, IdEx_JalrSel, IdEx_AluB_Pc4_Sel;
    logic        IdEx_MemRead, IdEx_MemWrite, IdEx_MemToReg, IdEx_RegWrite;
    logic [4:0]  ExMem_RegRd;
    logic        ExMem_RegWrite, ExMem_MemRead, ExMem_MemWrite, ExMem_MemToReg;
    logic [31:0] ExMem_AluResult, ExMem_StoreData;
    logic [2:0]  ExMem_Funct3;
    logic [4:0]  MemWb_RegRd;
    logic        MemWb_RegWrite;
    logic [31:0] Wb_RegWData;
    logic        Ex_IdExFlush, Ex_IfIdFlush, Ex_PcLoad;
    logic [31:0] Ex_PcTarget;

    int n_vec;
    int n_err;

    ex_stage #(.XLEN(32)) dut (
        .clk               (clk),
        .rstb              (rstb),
        .IdEx_Pc           (IdEx_Pc),
        .IdEx_RegDataA     (IdEx_RegDataA),
        .IdEx_RegDataB     (IdEx_RegDataB),
        .IdEx_Imm          (IdEx_Imm),
        .IdEx_RegRs1       (IdEx_RegRs1),
        .IdEx_RegRs2       (IdEx_RegRs2),
        .IdEx_RegRd        (IdEx_RegRd),
        .IdEx_Funct3       (IdEx_Funct3),
        .IdEx_AluOp        (IdEx_AluOp),
        .IdEx_AluSrc       (IdEx_AluSrc),
        .IdEx_Branch       (IdEx_Branch),
        .IdEx_PcSrc        (IdEx_PcSrc),
        .IdEx_JalrSel      (IdEx_JalrSel),
        .IdEx_AluB_Pc4_Sel (IdEx_AluB_Pc4_Sel),
        .IdEx_MemRead      (IdEx_MemRead),
        .IdEx_MemWrite     (IdEx_MemWrite),
        .IdEx_MemToReg     (IdEx_MemToReg),
        .IdEx_RegWrite     (IdEx_RegWrite),
        .ExMem_RegRd       (ExMem_RegRd),
        .ExMem_RegWrite    (ExMem_RegWrite),
        .ExMem_MemRead     (ExMem_MemRead),
        .ExMem_MemWrite    (ExMem_MemWrite),
        .ExMem_MemToReg    (ExMem_MemToReg),
        .ExMem_AluResult   (ExMem_AluResult),
        .ExMem_StoreData   (ExMem_StoreData),
        .ExMem_Funct3      (ExMem_Funct3),
        .MemWb_RegRd       (MemWb_RegRd),
        .MemWb_RegWrite    (MemWb_RegWrite),
        .Wb_RegWData       (Wb_RegWData),
        .Ex_IdExFlush      (Ex_IdExFlush),
        .Ex_IfIdFlush      (Ex_IfIdFlush),
        .Ex_PcLoad         (Ex_PcLoad),
        .Ex_PcTarget       (Ex_PcTarget)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and registers are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        IdEx_Pc = 32'h0; IdEx_RegDataA = 32'h0; IdEx_RegDataB = 32'h0; IdEx_Imm = 32'h0;
        IdEx_RegRs1 = 5'd0; IdEx_RegRs2 = 5'd0; IdEx_RegRd = 5'd0;
        IdEx_Funct3 = 3'd0; IdEx_AluOp = 4'd0;
        IdEx_AluSrc = 1'b0; IdEx_Branch = 1'b0; IdEx_PcSrc = 1'b0; IdEx_JalrSel = 1'b0;
        IdEx_AluB_Pc4_Sel = 1'b0;
        IdEx_MemRead = 1'b0; IdEx_MemWrite = 1'b0; IdEx_MemToReg = 1'b0; IdEx_RegWrite = 1'b0;
        MemWb_RegRd = 5'd0; MemWb_RegWrite = 1'b0; Wb_RegWData = 32'h0;
    endtask

    task automatic test_reset();
        set_idle();
        rstb = 1'b0;
        IdEx_RegWrite = 1'b1; IdEx_RegRd = 5'd5; IdEx_MemRead = 1'b1; IdEx_MemToReg = 1'b1;
        IdEx_RegDataA = 32'h11; IdEx_RegDataB = 32'h22; IdEx_Funct3 = 3'd2;
        step();
        step();
        n_vec++;
        if ({ExMem_RegRd, ExMem_RegWrite, ExMem_MemRead, ExMem_MemWrite, ExMem_MemToReg, ExMem_Funct3} !== 12'h0) begin
            n_err++;
            $display("FAIL reset_ctrl: got rd=%0d rw=%b mr=%b mw=%b m2r=%b f3=%0d, want all 0",
                     ExMem_RegRd, ExMem_RegWrite, ExMem_MemRead, ExMem_MemWrite, ExMem_MemToReg, ExMem_Funct3);
        end
        n_vec++;
        if ({ExMem_AluResult, ExMem_StoreData} !== 64'h0) begin
            n_err++;
            $display("FAIL reset_data: got res=%h sd=%h, want 0", ExMem_AluResult, ExMem_StoreData);
        end
        rstb = 1'b1;
        set_idle();
    endtask

    task automatic test_add();
        set_idle();
        IdEx_RegRs1 = 5'd1; IdEx_RegRs2 = 5'd2; IdEx_RegRd = 5'd3;
        IdEx_RegDataA = 32'd5; IdEx_RegDataB = 32'd7; IdEx_AluOp = 4'd0; IdEx_RegWrite = 1'b1;
        #1;
        n_vec++;
        if (Ex_PcLoad !== 1'b0) begin
            n_err++;
            $display("FAIL add_noredirect: PcLoad=%b, want 0", Ex_PcLoad);
        end
        step();
        n_vec++;
        if (ExMem_AluResult !== 32'd12 || ExMem_RegRd !== 5'd3 || ExMem_RegWrite !== 1'b1) begin
            n_err++;
            $display("FAIL add: res=%0d rd=%0d rw=%b, want 12 3 1", ExMem_AluResult, ExMem_RegRd, ExMem_RegWrite);
        end
        n_vec++;
        if (ExMem_StoreData !== 32'd7) begin
            n_err++;
            $display("FAIL add_storedata: got %0d, want 7", ExMem_StoreData);
        end
    endtask

    task automatic test_forwarding();
        // x1 = 100 via LUI-style pass-through
        set_idle();
        IdEx_AluOp = 4'd10; IdEx_AluSrc = 1'b1; IdEx_Imm = 32'd100; IdEx_RegRd = 5'd1; IdEx_RegWrite = 1'b1;
        step();
        n_vec++;
        if (ExMem_AluResult !== 32'd100) begin
            n_err++;
            $display("FAIL fwd_setup: got %0d, want 100", ExMem_AluResult);
        end
        // ADDI rs1=1, both stages match: EX/MEM wins
        set_idle();
        IdEx_RegRs1 = 5'd1; IdEx_RegDataA = 32'd7; IdEx_AluSrc = 1'b1; IdEx_Imm = 32'd1;
        IdEx_RegRd = 5'd4; IdEx_RegWrite = 1'b1;
        MemWb_RegRd = 5'd1; MemWb_RegWrite = 1'b1; Wb_RegWData = 32'd50;
        step();
        n_vec++;
        if (ExMem_AluResult !== 32'd101) begin
            n_err++;
            $display("FAIL fwd_exmem_prio: got %0d, want 101", ExMem_AluResult);
        end
        // Only MEM/WB matches now (EX/MEM holds rd=4); also retire into rd=0
        IdEx_RegRd = 5'd0;
        step();
        n_vec++;
        if (ExMem_AluResult !== 32'd51) begin
            n_err++;
            $display("FAIL fwd_memwb: got %0d, want 51", ExMem_AluResult);
        end
        // Index 0 on both stages with rs1=rs2=0: no forwarding
        set_idle();
        IdEx_RegRs1 = 5'd0; IdEx_RegRs2 = 5'd0; IdEx_RegDataA = 32'd7; IdEx_RegDataB = 32'd9;
        IdEx_AluSrc = 1'b1; IdEx_Imm = 32'd1; IdEx_RegRd = 5'd6; IdEx_RegWrite = 1'b1;
        MemWb_RegRd = 5'd0; MemWb_RegWrite = 1'b1; Wb_RegWData = 32'd50;
        step();
        n_vec++;
        if (ExMem_AluResult !== 32'd8 || ExMem_StoreData !== 32'd9) begin
            n_err++;
            $display("FAIL fwd_x0: res=%0d sd=%0d, want 8 9", ExMem_AluResult, ExMem_StoreData);
        end
        // rs2 forwarding: EX/MEM (x6=8) beats MEM/WB (x6=50)
        set_idle();
        IdEx_RegRs1 = 5'd2; IdEx_RegDataA = 32'd10; IdEx_RegRs2 = 5'd6; IdEx_RegDataB = 32'd1;
        IdEx_RegRd = 5'd7; IdEx_RegWrite = 1'b1;
        MemWb_RegRd = 5'd6; MemWb_RegWrite = 1'b1; Wb_RegWData = 32'd50;
        step();
        n_vec++;
        if (ExMem_AluResult !== 32'd18 || ExMem_StoreData !== 32'd8) begin
            n_err++;
            $display("FAIL fwd_rs2: res=%0d sd=%0d, want 18 8", ExMem_AluResult, ExMem_StoreData);
        end
    endtask

    task automatic test_branch();
        set_idle();
        IdEx_Pc = 32'h40; IdEx_Imm = 32'h20; IdEx_Branch = 1'b1; IdEx_Funct3 = 3'b000;
        IdEx_RegRs1 = 5'd10; IdEx_RegRs2 = 5'd11; IdEx_RegDataA = 32'd9; IdEx_RegDataB = 32'd9;
        #1;
        n_vec++;
        if ({Ex_PcLoad, Ex_IdExFlush, Ex_IfIdFlush} !== 3'b111 || Ex_PcTarget !== 32'h60) begin
            n_err++;
            $display("FAIL beq_taken: load/flush=%b%b%b tgt=%h, want 111 00000060",
                     Ex_PcLoad, Ex_IdExFlush, Ex_IfIdFlush, Ex_PcTarget);
        end
        IdEx_RegDataB = 32'd8;
        #1;
        n_vec++;
        if ({Ex_PcLoad, Ex_IdExFlush, Ex_IfIdFlush} !== 3'b000) begin
            n_err++;
            $display("FAIL beq_not_taken: load/flush=%b%b%b, want 000", Ex_PcLoad, Ex_IdExFlush, Ex_IfIdFlush);
        end
        IdEx_Funct3 = 3'b001;
        #1;
        n_vec++;
        if (Ex_PcLoad !== 1'b1 || Ex_PcTarget !== 32'h60) begin
            n_err++;
            $display("FAIL bne_taken: load=%b tgt=%h, want 1 00000060", Ex_PcLoad, Ex_PcTarget);
        end
        IdEx_Funct3 = 3'b010;
        IdEx_RegDataB = 32'd9;
        #1;
        n_vec++;
        if (Ex_PcLoad !== 1'b0) begin
            n_err++;
            $display("FAIL funct3_010: load=%b, want 0", Ex_PcLoad);
        end
        step();
        set_idle();
    endtask

    task automatic test_jalr_blt();
        set_idle();
        IdEx_AluOp = 4'd10; IdEx_AluSrc = 1'b1; IdEx_Imm = 32'h2003; IdEx_RegRd = 5'd5; IdEx_RegWrite = 1'b1;
        step();
        set_idle();
        IdEx_Pc = 32'h100; IdEx_Imm = 32'd4; IdEx_RegRs1 = 5'd5; IdEx_RegDataA = 32'h0;
        IdEx_Branch = 1'b1; IdEx_PcSrc = 1'b1; IdEx_JalrSel = 1'b1; IdEx_AluB_Pc4_Sel = 1'b1;
        IdEx_AluSrc = 1'b1; IdEx_RegRd = 5'd1; IdEx_RegWrite = 1'b1; IdEx_MemWrite = 1'b1;
        #1;
        n_vec++;
        if (Ex_PcLoad !== 1'b1 || Ex_PcTarget !== 32'h2006) begin
            n_err++;
            $display("FAIL jalr_target: load=%b tgt=%h, want 1 00002006", Ex_PcLoad, Ex_PcTarget);
        end
        step();
        n_vec++;
        if (ExMem_AluResult !== 32'h104 || ExMem_MemWrite !== 1'b0) begin
            n_err++;
            $display("FAIL jalr_link: res=%h mw=%b, want 00000104 0", ExMem_AluResult, ExMem_MemWrite);
        end
        set_idle();
        IdEx_Pc = 32'h200; IdEx_Imm = 32'hFFFF_FFF8; IdEx_Branch = 1'b1;
        IdEx_RegRs1 = 5'd12; IdEx_RegRs2 = 5'd13; IdEx_RegDataA = 32'hFFFF_FFFF; IdEx_RegDataB = 32'd1;
        IdEx_Funct3 = 3'b100;
        #1;
        n_vec++;
        if (Ex_PcLoad !== 1'b1 || Ex_PcTarget !== 32'h1F8) begin
            n_err++;
            $display("FAIL blt_taken: load=%b tgt=%h, want 1 000001f8", Ex_PcLoad, Ex_PcTarget);
        end
        IdEx_Funct3 = 3'b110;
        #1;
        n_vec++;
        if (Ex_PcLoad !== 1'b0 || Ex_PcTarget !== 32'h204) begin
            n_err++;
            $display("FAIL bltu_not_taken: load=%b tgt=%h, want 0 00000204", Ex_PcLoad, Ex_PcTarget);
        end
        IdEx_Funct3 = 3'b101;
        #1;
        n_vec++;
        if (Ex_PcLoad !== 1'b0) begin
            n_err++;
            $display("FAIL bge_not_taken: load=%b, want 0", Ex_PcLoad);
        end
        IdEx_Funct3 = 3'b111;
        #1;
        n_vec++;
        if (Ex_PcLoad !== 1'b1) begin
            n_err++;
            $display("FAIL bgeu_taken: load=%b, want 1", Ex_PcLoad);
        end
        step();
        set_idle();
    endtask

    task automatic test_alu();
        logic [3:0]  ops [7];
        logic [31:0] av  [7];
        logic [31:0] bv  [7];
        logic [31:0] exp [7];
        ops[0] = 4'd7;  av[0] = 32'h8000_0000; bv[0] = 32'h24;        exp[0] = 32'hF800_0000;
        ops[1] = 4'd4;  av[1] = 32'h0;         bv[1] = 32'h1;         exp[1] = 32'h1;
        ops[2] = 4'd13; av[2] = 32'd5;         bv[2] = 32'd7;         exp[2] = 32'h0;
        ops[3] = 4'd3;  av[3] = 32'hFFFF_FFFF; bv[3] = 32'h1;         exp[3] = 32'h1;
        ops[4] = 4'd1;  av[4] = 32'd5;         bv[4] = 32'd7;         exp[4] = 32'hFFFF_FFFE;
        ops[5] = 4'd11; av[5] = 32'hDEAD;      bv[5] = 32'h234;       exp[5] = 32'h1234;
        ops[6] = 4'd6;  av[6] = 32'h8000_0000; bv[6] = 32'h24;        exp[6] = 32'h0800_0000;
        for (int i = 0; i < 7; i++) begin
            set_idle();
            IdEx_Pc = 32'h1000; IdEx_RegRs1 = 5'd20; IdEx_RegRs2 = 5'd21; IdEx_RegRd = 5'd22;
            IdEx_RegWrite = 1'b1; IdEx_AluSrc = 1'b1;
            IdEx_AluOp = ops[i]; IdEx_RegDataA = av[i]; IdEx_Imm = bv[i];
            step();
            n_vec++;
            if (ExMem_AluResult !== exp[i]) begin
                n_err++;
                $display("FAIL alu_op%0d: got %h, want %h", ops[i], ExMem_AluResult, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        set_idle();
        IdEx_RegRs1 = 5'd1; IdEx_RegRs2 = 5'd2; IdEx_RegRd = 5'd3; IdEx_RegWrite = 1'b1;
        IdEx_RegDataA = 32'd5; IdEx_RegDataB = 32'd7; IdEx_Funct3 = 3'd2; IdEx_MemRead = 1'b1;
        step();
        rstb = 1'b0;
        IdEx_Branch = 1'b1; IdEx_PcSrc = 1'b1; IdEx_Pc = 32'h80; IdEx_Imm = 32'h10;
        #1;
        n_vec++;
        if (Ex_PcLoad !== 1'b1 || Ex_PcTarget !== 32'h90) begin
            n_err++;
            $display("FAIL reset_comb: load=%b tgt=%h, want 1 00000090", Ex_PcLoad, Ex_PcTarget);
        end
        step();
        n_vec++;
        if ({ExMem_RegRd, ExMem_RegWrite, ExMem_MemRead, ExMem_Funct3} !== 10'h0 ||
            ExMem_AluResult !== 32'h0 || ExMem_StoreData !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid: rd=%0d rw=%b mr=%b f3=%0d res=%h sd=%h, want all 0",
                     ExMem_RegRd, ExMem_RegWrite, ExMem_MemRead, ExMem_Funct3, ExMem_AluResult, ExMem_StoreData);
        end
        rstb = 1'b1;
        IdEx_Branch = 1'b0; IdEx_PcSrc = 1'b0;
        step();
        n_vec++;
        if (ExMem_AluResult !== 32'd12 || ExMem_RegRd !== 5'd3 || ExMem_MemRead !== 1'b1) begin
            n_err++;
            $display("FAIL reset_resume: res=%0d rd=%0d mr=%b, want 12 3 1", ExMem_AluResult, ExMem_RegRd, ExMem_MemRead);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rstb  = 1'b0;
        set_idle();
        #1;
        test_reset();
        test_add();
        test_forwarding();
        test_branch();
        test_jalr_blt();
        test_alu();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
